mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Round-robin arbiter sharing one DDR4 DIMM memory bus among N requesters (LLC slices, DMA).
// - Sits between the requesters' mem_bus_* ports and the DIMM command/data decode.
// - Grants one requester per burst and forwards its addr/valid/ready to the bus.
// - Enforces a bus-turnaround gap between owners on the shared bidirectional dqs.
// PARAMETERS
// - N            2   number of requesters (>=2)
// - PADDR_BITS   19  width of mem_bus_addr (cs_N, act, addr fields)
// - BURST_BEATS  8   beats per transaction (64B line / 8B beat)
// - TURN_CYCLES  2   idle cycles between owners (0 = direct to IDLE)
// - TIMEOUT      64  max consecutive beat-less GRANT cycles (MEM_ARB_TIMEOUT_EN only)
// PORTS
// - clk_in             in   1             clock, all state on rising edge
// - rst_N_in           in   1             asynchronous active-low reset
// - req_valid_in       in   N             requester i wants/holds the bus
// - req_addr_in        in   N*PADDR_BITS  slice i = requester i mem_bus_addr
// - req_valid_out_in   in   N             requester i write-beat valid
// - req_ready_out_in   in   N             requester i ready for read beat
// - grant_out          in/out -> out N    one-hot owner; also gates requester dqs drivers
// - req_valid_in_out   out  N             mem_bus_valid_in routed to owner only
// - req_ready_in_out   out  N             mem_bus_ready_in routed to owner only
// - mem_bus_addr_out   out  PADDR_BITS    owner address, 0 when no owner
// - mem_bus_valid_out  out  1             owner write-beat valid
// - mem_bus_ready_out  out  1             owner read-beat ready
// - mem_bus_valid_in   in   1             DIMM read-beat valid
// - mem_bus_ready_in   in   1             DIMM ready for write beat
// - busy_out           out  1             state != IDLE
// - timeout_out        out  1             1-cycle pulse on watchdog release
// BEHAVIOUR
// - Reset values: state IDLE; rr_ptr 0; beat_cnt 0; all outputs 0. Reset is asynchronous, so an
//   assertion mid-GRANT zeroes grant and the bus outputs immediately.
// - States: IDLE -> GRANT -> TURN -> IDLE.
// - IDLE, any req_valid_in:
//   - pick the first set bit scanning from rr_ptr upward, mod N;
//   - register grant_out, so grant appears 1 cycle after the request;
//   - rr_ptr <= winner+1 mod N; beat_cnt <= 0.
// - GRANT:
//   - mux the owner's addr/valid_out/ready_out onto the bus;
//   - route mem_bus_valid_in/ready_in to the owner bit only; non-owners see 0.
// - Beat:
//   - (mem_bus_valid_in & owner ready_out) | (owner valid_out & mem_bus_ready_in);
//   - a cycle with both counts as one beat.
// - Release to TURN when either:
//   - beat occurs with beat_cnt==BURST_BEATS-1; or
//   - owner drops req_valid_in (abort, partial burst; beat that cycle ignored).
// - Release: grant_out <= 0 the next cycle; beat_cnt clears.
// - TURN: all bus outputs 0 for TURN_CYCLES cycles, then IDLE.
//   - TURN_CYCLES==0: GRANT -> IDLE directly.
// - A request arriving during GRANT/TURN waits; arbitration happens only in IDLE.
// - Owner holding req_valid_in after its burst re-competes; round-robin gives the other
//   requesters priority.
// - beat_cnt width clog2(BURST_BEATS); saturates, never wraps.
// - Non-granted requester inputs have no effect on any output.
// CONFIGURATION
// - MEM_ARB_TIMEOUT_EN defined:
//   - watchdog counts consecutive GRANT cycles without a beat; reset on each beat;
//   - on reaching TIMEOUT: timeout_out=1 for 1 cycle, forced release to TURN, rr_ptr advances.
// - MEM_ARB_TIMEOUT_EN undefined: no watchdog logic; timeout_out tied 0.
// TESTING
// - Reset: rst_N_in=0 -> grant_out=0, mem_bus_addr_out=0, busy_out=0, timeout_out=0.
// - Single burst: req_valid_in=01 at cycle 0 -> grant_out=01 at cycle 1;
//   8 read beats -> grant_out=00 next cycle; 2 TURN cycles, then busy_out=0.
// - Contention: req_valid_in=11 held -> grants 01,10,01,10; 2-cycle gap each;
//   addr_out tracks owner slice.
// - Abort: owner drops req_valid_in after 3 beats -> release next cycle;
//   the other requester is granted after TURN.
// - Timeout (EN): granted, no beats for 64 cycles -> timeout_out pulse 1 cycle, grant_out=0.
// - Async reset mid-GRANT -> outputs 0 in the same cycle; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one DDR4 DIMM bus among N requesters, one burst per grant.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that releases an owner stalled without beats.
module mem_bus_arbiter #(
  parameter int N           = 2,
  parameter int PADDR_BITS  = 19,
  parameter int BURST_BEATS = 8,
  parameter int TURN_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_N_in,
  input  logic [N-1:0]            req_valid_in,
  input  logic [N*PADDR_BITS-1:0] req_addr_in,
  input  logic [N-1:0]            req_valid_out_in,
  input  logic [N-1:0]            req_ready_out_in,
  output logic [N-1:0]            grant_out,
  output logic [N-1:0]            req_valid_in_out,
  output logic [N-1:0]            req_ready_in_out,
  output logic [PADDR_BITS-1:0]   mem_bus_addr_out,
  output logic                    mem_bus_valid_out,
  output logic                    mem_bus_ready_out,
  input  logic                    mem_bus_valid_in,
  input  logic                    mem_bus_ready_in,
  output logic                    busy_out,
  output logic                    timeout_out
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int TRN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
  localparam logic [TRN_W-1:0] LAST_TURN = TRN_W'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
  localparam logic [PTR_W:0]   N_EXT     = (PTR_W + 1)'(N);

  if (N < 2 || BURST_BEATS < 1 || TURN_CYCLES < 0 || TIMEOUT < 1) begin : g_param_check
    $error("mem_bus_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t            state_r;
  logic [N-1:0]      grant_r;
  logic [PTR_W-1:0]  owner_r;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic [TRN_W-1:0]  turn_cnt_r;
  logic              busy_r;

  logic [PTR_W:0]    arb_sum_s;
  logic [PTR_W-1:0]  winner_s;
  logic [PTR_W-1:0]  next_ptr_s;
  logic [N-1:0]      grant_nxt_s;
  logic              gnt_act_s;
  logic              own_req_s;
  logic              own_vo_s;
  logic              own_ro_s;
  logic [PADDR_BITS-1:0] own_addr_s;
  logic              beat_s;
  logic              last_s;
  logic              wd_fire_s;
  logic              release_s;

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins last.
  always_comb begin
    winner_s  = '0;
    arb_sum_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      arb_sum_s = {1'b0, rr_ptr_r} + (PTR_W + 1)'(i);
      arb_sum_s = (arb_sum_s >= N_EXT) ? (arb_sum_s - N_EXT) : arb_sum_s;
      winner_s  = req_valid_in[arb_sum_s[PTR_W-1:0]] ? arb_sum_s[PTR_W-1:0] : winner_s;
    end
  end

  // One-hot form of the arbitration winner.
  always_comb begin
    grant_nxt_s           = '0;
    grant_nxt_s[winner_s] = 1'b1;
  end

  assign next_ptr_s = (winner_s == PTR_W'(N - 1)) ? '0 : (winner_s + PTR_W'(1));

  assign gnt_act_s  = (state_r == ST_GRANT);
  assign own_req_s  = req_valid_in[owner_r];
  assign own_vo_s   = req_valid_out_in[owner_r];
  assign own_ro_s   = req_ready_out_in[owner_r];
  assign own_addr_s = req_addr_in[owner_r*PADDR_BITS +: PADDR_BITS];

  assign beat_s    = (mem_bus_valid_in & own_ro_s) | (own_vo_s & mem_bus_ready_in);
  assign last_s    = beat_s & (beat_cnt_r == LAST_BEAT);
  assign release_s = ~own_req_s | last_s | wd_fire_s;

  // The handshake path stays combinational so a beat completes in the cycle it is offered;
  // every term is gated by the registered grant, so reset clears it at once.
  assign grant_out         = grant_r;
  assign busy_out          = busy_r;
  assign mem_bus_addr_out  = gnt_act_s ? own_addr_s : '0;
  assign mem_bus_valid_out = gnt_act_s & own_vo_s;
  assign mem_bus_ready_out = gnt_act_s & own_ro_s;
  assign req_valid_in_out  = grant_r & {N{mem_bus_valid_in}};
  assign req_ready_in_out  = grant_r & {N{mem_bus_ready_in}};

  // Ownership FSM: arbitrate in IDLE, count burst beats in GRANT, hold the bus quiet in TURN.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      turn_cnt_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_valid_in) begin
            state_r    <= ST_GRANT;
            busy_r     <= 1'b1;
            grant_r    <= grant_nxt_s;
            owner_r    <= winner_s;
            rr_ptr_r   <= next_ptr_s;
            beat_cnt_r <= '0;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            grant_r    <= '0;
            beat_cnt_r <= '0;
            turn_cnt_r <= '0;
            if (TURN_CYCLES == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_TURN;
            end
          end else if (beat_s) begin
            beat_cnt_r <= (beat_cnt_r == LAST_BEAT) ? beat_cnt_r : (beat_cnt_r + CNT_W'(1));
          end
        end
        ST_TURN: begin
          if (turn_cnt_r == LAST_TURN) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            turn_cnt_r <= '0;
          end else begin
            turn_cnt_r <= turn_cnt_r + TRN_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          grant_r    <= '0;
          busy_r     <= 1'b0;
          beat_cnt_r <= '0;
          turn_cnt_r <= '0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_r;

  // An abort takes precedence, so the watchdog only fires while the owner still requests.
  assign wd_fire_s   = gnt_act_s & own_req_s & ~beat_s & (wd_cnt_r == WD_LAST);
  assign timeout_out = timeout_r;

  // Watchdog over consecutive beat-less GRANT cycles and its one-cycle release pulse.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      wd_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= wd_fire_s;
      if (gnt_act_s && !release_s && !beat_s) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end else begin
        wd_cnt_r <= '0;
      end
    end
  end
`else
  assign wd_fire_s   = 1'b0;
  assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus randomized traffic for mem_bus_arbiter, checked against a
// burst-level reference model of ownership, turnaround gaps and round-robin order.
module tb_mem_bus_arbiter;

  localparam int N           = 2;
  localparam int PADDR_BITS  = 19;
  localparam int BURST_BEATS = 8;
  localparam int TURN_CYCLES = 2;
  localparam int TIMEOUT     = 64;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                    clk_in;
  logic                    rst_N_in;
  logic [N-1:0]            req_valid_in;
  logic [N*PADDR_BITS-1:0] req_addr_in;
  logic [N-1:0]            req_valid_out_in;
  logic [N-1:0]            req_ready_out_in;
  logic [N-1:0]            grant_out;
  logic [N-1:0]            req_valid_in_out;
  logic [N-1:0]            req_ready_in_out;
  logic [PADDR_BITS-1:0]   mem_bus_addr_out;
  logic                    mem_bus_valid_out;
  logic                    mem_bus_ready_out;
  logic                    mem_bus_valid_in;
  logic                    mem_bus_ready_in;
  logic                    busy_out;
  logic                    timeout_out;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 none), beats done, quiet cycles left, rr pointer.
  int m_own;
  int m_beats;
  int m_gap;
  int m_ptr;
  int m_idle;
  bit m_to;

  mem_bus_arbiter #(
    .N(N), .PADDR_BITS(PADDR_BITS), .BURST_BEATS(BURST_BEATS),
    .TURN_CYCLES(TURN_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .req_valid_in(req_valid_in), .req_addr_in(req_addr_in),
    .req_valid_out_in(req_valid_out_in), .req_ready_out_in(req_ready_out_in),
    .grant_out(grant_out), .req_valid_in_out(req_valid_in_out),
    .req_ready_in_out(req_ready_in_out), .mem_bus_addr_out(mem_bus_addr_out),
    .mem_bus_valid_out(mem_bus_valid_out), .mem_bus_ready_out(mem_bus_ready_out),
    .mem_bus_valid_in(mem_bus_valid_in), .mem_bus_ready_in(mem_bus_ready_in),
    .busy_out(busy_out), .timeout_out(timeout_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_beats = 0; m_gap = 0; m_ptr = 0; m_idle = 0; m_to = 1'b0;
  endtask

  task automatic check_model();
    logic [63:0]           eg;
    logic [PADDR_BITS-1:0] ea;
    logic                  ev;
    logic                  er;
    eg = 64'd0; ea = '0; ev = 1'b0; er = 1'b0;
    if (m_own >= 0) begin
      eg[m_own] = 1'b1;
      ea = req_addr_in[m_own*PADDR_BITS +: PADDR_BITS];
      ev = req_valid_out_in[m_own];
      er = req_ready_out_in[m_own];
    end
    chk("grant", 64'(grant_out), eg);
    chk("busy", 64'(busy_out), 64'(m_own >= 0 || m_gap > 0));
    chk("addr", 64'(mem_bus_addr_out), 64'(ea));
    chk("bus_valid", 64'(mem_bus_valid_out), 64'(ev));
    chk("bus_ready", 64'(mem_bus_ready_out), 64'(er));
    chk("route_valid", 64'(req_valid_in_out), mem_bus_valid_in ? eg : 64'd0);
    chk("route_ready", 64'(req_ready_in_out), mem_bus_ready_in ? eg : 64'd0);
    chk("timeout", 64'(timeout_out), 64'(m_to));
  endtask

  task automatic model_advance();
    bit beat;
    bit rel;
    bit found;
    int idx;
    m_to = 1'b0;
    if (!rst_N_in) begin
      model_reset();
    end else if (m_own >= 0) begin
      beat = (mem_bus_valid_in && req_ready_out_in[m_own]) ||
             (req_valid_out_in[m_own] && mem_bus_ready_in);
      rel = 1'b0;
      if (!req_valid_in[m_own]) begin
        rel = 1'b1;
      end else if (beat) begin
        m_beats++;
        m_idle = 0;
        rel = (m_beats == BURST_BEATS);
      end else begin
        m_idle++;
        if (TO_EN && m_idle == TIMEOUT) begin
          rel = 1'b1;
          m_to = 1'b1;
        end
      end
      if (rel) begin
        m_own = -1;
        m_gap = TURN_CYCLES;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_valid_in[idx]) begin
          found = 1'b1;
          m_own = idx;
          m_ptr = (idx + 1) % N;
          m_beats = 0;
          m_idle = 0;
        end
      end
    end
  endtask

  // Check mid-cycle, advance the model on the edge, hand back just after the edge.
  task automatic step();
    @(negedge clk_in);
    check_model();
    @(posedge clk_in);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst_N_in = 1'b0;
    model_reset();
    step();
    rst_N_in = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq [4];
    logic [N-1:0] exp_seq [4];
    logic [N-1:0] prev;
    int ng;

    rst_N_in = 1'b1;
    req_valid_in = '0; req_addr_in = '0; req_valid_out_in = '0; req_ready_out_in = '0;
    mem_bus_valid_in = 1'b0; mem_bus_ready_in = 1'b0;
    model_reset();
    #1;
    rst_N_in = 1'b0;
    #1;
    chk("rst_grant", 64'(grant_out), 64'd0);
    chk("rst_addr", 64'(mem_bus_addr_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_timeout", 64'(timeout_out), 64'd0);
    step();
    step();
    rst_N_in = 1'b1;

    // Single 8-beat read burst from requester 0.
    req_addr_in = {19'h2AAAA, 19'h01234};
    req_valid_in = 2'b01; req_ready_out_in = 2'b01; mem_bus_valid_in = 1'b1;
    step();
    chk("single_grant", 64'(grant_out), 64'd1);
    chk("single_addr", 64'(mem_bus_addr_out), 64'h01234);
    repeat (BURST_BEATS) step();
    req_valid_in = 2'b00;
    chk("single_release", 64'(grant_out), 64'd0);
    chk("single_turn_busy0", 64'(busy_out), 64'd1);
    step();
    chk("single_turn_busy1", 64'(busy_out), 64'd1);
    step();
    chk("single_idle", 64'(busy_out), 64'd0);

    // Contention with both requesting continuously: alternating ownership.
    do_reset();
    req_addr_in = {19'h5A5A5, 19'h12345};
    req_valid_in = 2'b11; req_ready_out_in = 2'b11; mem_bus_valid_in = 1'b1;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    ng = 0;
    prev = '0;
    for (int c = 0; c < 60; c++) begin
      if (grant_out != '0 && prev == '0 && ng < 4) begin
        seq[ng] = grant_out;
        ng++;
      end
      prev = grant_out;
      step();
    end
    chk("cont_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_order", 64'(seq[i]), 64'(exp_seq[i]));
    end

    // Owner 0 aborts after three beats; requester 1 is granted after the gap.
    do_reset();
    req_valid_in = 2'b11; req_ready_out_in = 2'b11; mem_bus_valid_in = 1'b1;
    step();
    step();
    step();
    step();
    req_valid_in = 2'b10;
    chk("abort_hold", 64'(grant_out), 64'd1);
    step();
    chk("abort_release", 64'(grant_out), 64'd0);
    chk("abort_busy", 64'(busy_out), 64'd1);
    step();
    step();
    step();
    chk("abort_next_owner", 64'(grant_out), 64'd2);
    chk("abort_next_addr", 64'(mem_bus_addr_out), 64'h5A5A5);

`ifdef MEM_ARB_TIMEOUT_EN
    // Granted owner stalls with no beats until the watchdog releases it.
    do_reset();
    req_valid_in = 2'b01; req_ready_out_in = 2'b00; req_valid_out_in = 2'b00;
    mem_bus_valid_in = 1'b0; mem_bus_ready_in = 1'b0;
    step();
    chk("wd_grant", 64'(grant_out), 64'd1);
    repeat (TIMEOUT) step();
    chk("wd_pulse", 64'(timeout_out), 64'd1);
    chk("wd_release", 64'(grant_out), 64'd0);
    req_valid_in = 2'b00;
    step();
    chk("wd_pulse_end", 64'(timeout_out), 64'd0);
`endif

    // Randomized traffic, including non-owner activity and aborts.
    do_reset();
    req_valid_in = '0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 31) == 0) req_valid_in[b] = ~req_valid_in[b];
      end
      req_valid_out_in = N'($urandom);
      req_ready_out_in = N'($urandom);
      mem_bus_valid_in = 1'($urandom_range(0, 1));
      mem_bus_ready_in = 1'($urandom_range(0, 1));
      req_addr_in      = (N*PADDR_BITS)'({$urandom, $urandom});
      step();
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req_valid_in = 2'b11; req_ready_out_in = 2'b11; mem_bus_valid_in = 1'b1;
    mem_bus_ready_in = 1'b1; req_valid_out_in = 2'b11;
    step();
    step();
    chk("arst_pre_grant", 64'(grant_out), 64'd1);
    rst_N_in = 1'b0;
    #1;
    chk("arst_grant", 64'(grant_out), 64'd0);
    chk("arst_addr", 64'(mem_bus_addr_out), 64'd0);
    chk("arst_bus_valid", 64'(mem_bus_valid_out), 64'd0);
    chk("arst_route_valid", 64'(req_valid_in_out), 64'd0);
    chk("arst_busy", 64'(busy_out), 64'd0);
    model_reset();
    step();
    rst_N_in = 1'b1;
    step();
    chk("arst_first_grant", 64'(grant_out), 64'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
